edubos5_rf_gen: RTL

//  Parametrised successor to the eduBOS5 integer register file: N async read ports, 1 sync write port.

---
 rtl/edubos5_rf_gen.sv | 91 +++++++++
 1 files changed

// File: rtl/edubos5_rf_gen.sv
// eduBOS5 integer register file: NRD async read ports, one sync write port, hardware clear sequencer.
// Optional write-to-read forwarding is enabled by defining EDUBOS5_RF_BYPASS_EN.
module edubos5_rf_gen #(
    parameter  int unsigned XLEN  = 32,
    parameter  int unsigned NREGS = 32,
    parameter  int unsigned NRD   = 2,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs,
    input  logic [AW-1:0]       rd_addr,
    input  logic                rf_we,
    input  logic [XLEN-1:0]     rf_wdat,
    input  logic                clr_req,
    output logic                rf_rdy,
    output logic                wr_drop
);

    typedef enum logic {
        CLEAR,
        READY
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   clr_cnt_q;
    logic            rdy_q;
    logic            drop_q;
    logic [XLEN-1:0] rf_q [NREGS];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= AW'(1);
            rdy_q     <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (rf_we && rd_addr != '0) begin
                        drop_q <= 1'b1;
                    end
                    if (clr_cnt_q == AW'(NREGS - 1)) begin
                        state_q <= READY;
                        rdy_q   <= 1'b1;
                    end
                    clr_cnt_q <= clr_cnt_q + AW'(1);
                end
                READY: begin
                    if (clr_req) begin
                        state_q   <= CLEAR;
                        clr_cnt_q <= AW'(1);
                        rdy_q     <= 1'b0;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    // Array stays un-reset distributed RAM; entry 0 is never written nor observed.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            rf_q[clr_cnt_q] <= '0;
        end else if (rf_we && rd_addr != '0) begin
            rf_q[rd_addr] <= rf_wdat;
        end
    end

    always_comb begin
        rs = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            if (rdy_q && rs_addr[i*AW +: AW] != '0) begin
`ifdef EDUBOS5_RF_BYPASS_EN
                if (rf_we && rd_addr == rs_addr[i*AW +: AW]) begin
                    rs[i*XLEN +: XLEN] = rf_wdat;
                end else begin
                    rs[i*XLEN +: XLEN] = rf_q[rs_addr[i*AW +: AW]];
                end
`else
                rs[i*XLEN +: XLEN] = rf_q[rs_addr[i*AW +: AW]];
`endif
            end
        end
    end

    assign rf_rdy  = rdy_q;
    assign wr_drop = drop_q;

endmodule
